// File: rtl/cmd_sequencer.sv
// cmd_sequencer: program store and run controller for a cpu command-fetch port.
// A host streams a program into the internal RAM. On run, the block serves the
// command at the cpu's fetch address with one cycle of registered latency and
// holds cmd_en high. Results from the cpu go into a small show-ahead FIFO, and
// the cpu is stopped after RES_MAX results.
//
// Ports
//   sys_clk, sys_rst_n           clock (rising edge), async active-low reset
//   ld_start/ld_data/ld_valid    program load stream; ld_ready = word accepted
//   ld_done                      end of load, latches prog_len
//   run                          start or restart execution
//   cmd_id -> cmd, cmd_en        fetch address in, command out (1-cycle), cpu enable
//   res, res_en                  cpu result and its strobe (rising edge counts)
//   rd_en, rd_data, rd_empty     result FIFO pop / head / empty
//   busy, prog_len, err          status; err[0] fetch out of range, err[1] overflow
module cmd_sequencer #(
  parameter int CMD_W     = 32,
  parameter int ID_W      = 16,
  parameter int DEPTH     = 64,
  parameter int RES_MAX   = 1,
  parameter int RES_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             ld_start,
  input  logic [CMD_W-1:0] ld_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_done,
  input  logic             run,
  input  logic [ID_W-1:0]  cmd_id,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_en,
  input  logic [CMD_W-1:0] res,
  input  logic             res_en,
  input  logic             rd_en,
  output logic [CMD_W-1:0] rd_data,
  output logic             rd_empty,
  output logic             busy,
  output logic [ID_W:0]    prog_len,
  output logic [1:0]       err
);
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;          // RAM address
  localparam int WPW = $clog2(DEPTH + 1);                         // wr_ptr reaches DEPTH
  localparam int CW  = (RES_MAX > 0) ? $clog2(RES_MAX + 1) : 1;   // result count
  localparam int FAW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;   // FIFO pointer
  localparam int FCW = $clog2(RES_DEPTH + 1);                     // FIFO fill level
  localparam int PLW = ID_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CMD_W-1:0] mem  [DEPTH];
  logic [CMD_W-1:0] fifo [RES_DEPTH];
  logic [WPW-1:0]   wr_ptr;
  logic [CW-1:0]    res_cnt;
  logic             res_en_q;
  logic [FAW-1:0]   f_wp, f_rp;
  logic [FCW-1:0]   f_cnt;

  logic ld_acc, ld_err, in_range, res_edge, f_full, f_empty;
  logic push, pop, drop, cnt_inc, cnt_hit;

  always_comb begin
    ld_ready = (state == S_LOAD) && (wr_ptr < WPW'(DEPTH));
    ld_acc   = ld_valid & ld_ready;
    ld_err   = (state == S_LOAD) & ld_valid & ~ld_ready;
    in_range = ({1'b0, cmd_id} < prog_len);
    res_edge = (state == S_RUN) & res_en & ~res_en_q;
    f_empty  = (f_cnt == '0);
    f_full   = (f_cnt == FCW'(RES_DEPTH));
    pop      = rd_en & ~f_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = res_edge & (~f_full | pop);
    drop     = res_edge & f_full & ~pop;
    cnt_inc  = res_edge && (res_cnt != CW'(RES_MAX));
    cnt_hit  = (RES_MAX != 0) && res_edge && (res_cnt == CW'(RES_MAX - 1));
    busy     = (state == S_LOAD) || (state == S_RUN);
    rd_empty = f_empty;
    rd_data  = f_empty ? '0 : fifo[f_rp];
  end

  // Program RAM and FIFO storage carry no reset.
  always_ff @(posedge sys_clk) begin
    if (ld_acc) mem[wr_ptr[MAW-1:0]] <= ld_data;
    if (push)   fifo[f_wp] <= res;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (push) f_wp <= (f_wp == FAW'(RES_DEPTH - 1)) ? '0 : f_wp + 1'b1;
      if (pop)  f_rp <= (f_rp == FAW'(RES_DEPTH - 1)) ? '0 : f_rp + 1'b1;
      f_cnt <= f_cnt + FCW'(push) - FCW'(pop);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      cmd      <= '0;
      cmd_en   <= 1'b0;
      prog_len <= '0;
      wr_ptr   <= '0;
      res_cnt  <= '0;
      res_en_q <= 1'b0;
      err      <= 2'b00;
    end else begin
      res_en_q <= res_en;
      if (state == S_RUN) begin
        cmd <= in_range ? mem[cmd_id[MAW-1:0]] : '0;
        if (!in_range) err[0] <= 1'b1;
      end
      if (ld_err || drop) err[1] <= 1'b1;
      if (ld_acc)  wr_ptr  <= wr_ptr + 1'b1;
      if (cnt_inc) res_cnt <= res_cnt + 1'b1;
      // ld_start wins over everything else, from any state.
      if (ld_start) begin
        state  <= S_LOAD;
        wr_ptr <= '0;
        cmd_en <= 1'b0;
      end else begin
        case (state)
          S_LOAD: if (ld_done) begin
            state    <= S_IDLE;
            // A word accepted alongside ld_done counts toward the length.
            prog_len <= PLW'(wr_ptr + WPW'(ld_acc));
          end
          S_IDLE, S_DONE: if (run && prog_len != '0) begin
            state   <= S_RUN;
            res_cnt <= '0;
            cmd_en  <= 1'b1;
          end
          S_RUN: if (cnt_hit) begin
            state  <= S_DONE;
            cmd_en <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_sequencer.sv
module tb_cmd_sequencer;
  localparam int CMD_W = 32, ID_W = 8, DEPTH = 16;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic ld_start = 0, ld_valid = 0, ld_done = 0, run = 0, res_en = 0, rd_en = 0;
  logic [CMD_W-1:0] ld_data = '0, res = '0;
  logic [ID_W-1:0]  cmd_id = '0;

  logic [CMD_W-1:0] cmd_a, rd_data_a, cmd_b, rd_data_b;
  logic             ld_ready_a, cmd_en_a, rd_empty_a, busy_a;
  logic             ld_ready_b, cmd_en_b, rd_empty_b, busy_b;
  logic [ID_W:0]    prog_len_a, prog_len_b;
  logic [1:0]       err_a, err_b;

  always #5 sys_clk = ~sys_clk;

  // a: stops after one result; b: never stops on count (FIFO tests)
  cmd_sequencer #(.CMD_W(CMD_W), .ID_W(ID_W), .DEPTH(DEPTH), .RES_MAX(1), .RES_DEPTH(4)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ld_start(ld_start), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_done(ld_done), .run(run),
    .cmd_id(cmd_id), .cmd(cmd_a), .cmd_en(cmd_en_a), .res(res), .res_en(res_en),
    .rd_en(rd_en), .rd_data(rd_data_a), .rd_empty(rd_empty_a), .busy(busy_a),
    .prog_len(prog_len_a), .err(err_a));

  cmd_sequencer #(.CMD_W(CMD_W), .ID_W(ID_W), .DEPTH(DEPTH), .RES_MAX(0), .RES_DEPTH(4)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ld_start(ld_start), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_done(ld_done), .run(run),
    .cmd_id(cmd_id), .cmd(cmd_b), .cmd_en(cmd_en_b), .res(res), .res_en(res_en),
    .rd_en(rd_en), .rd_data(rd_data_b), .rd_empty(rd_empty_b), .busy(busy_b),
    .prog_len(prog_len_b), .err(err_b));

  int ncmp = 0, nerr = 0;
  logic [CMD_W-1:0] exp_q[$];
  logic [CMD_W-1:0] prog[15];
  logic [CMD_W-1:0] e;
  int acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  initial begin
    // program whose low halves sum to 5050 (0x13BA)
    for (int i = 0; i < 14; i++) prog[i] = 32'hA500_0000 | (300 + i);
    prog[14] = 32'hA500_0000 | 759;

    // reset state
    #3;
    chk("rst_cmd", cmd_a, 0);          chk("rst_cmd_en", cmd_en_a, 0);
    chk("rst_ld_ready", ld_ready_a, 0); chk("rst_prog_len", prog_len_a, 0);
    chk("rst_empty", rd_empty_a, 1);   chk("rst_rd_data", rd_data_a, 0);
    chk("rst_err", err_a, 0);          chk("rst_busy", busy_a, 0);
    tick(); tick();
    #2 sys_rst_n = 1'b1;
    tick();

    // run with empty program is ignored
    run = 1; tick(); run = 0; tick();
    chk("run_empty_busy", busy_a, 0); chk("run_empty_cmd_en", cmd_en_a, 0);

    // load 15 words, last one together with ld_done
    ld_start = 1; tick(); ld_start = 0;
    chk("load_ready", ld_ready_a, 1); chk("load_busy", busy_a, 1);
    for (int i = 0; i < 15; i++) begin
      ld_data = prog[i]; ld_valid = 1; ld_done = (i == 14); tick();
    end
    ld_valid = 0; ld_done = 0;
    chk("prog_len_15", prog_len_a, 15); chk("load_idle", busy_a, 0);

    // run: cmd_en the cycle after run, cpu fetches sequentially
    run = 1; tick(); run = 0;
    chk("run_cmd_en", cmd_en_a, 1); chk("run_busy", busy_a, 1);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      cmd_id = ID_W'(i);
      exp_q.push_back(i < 15 ? prog[i] : '0);
      tick();
      e = exp_q.pop_front();
      chk("fetch_cmd", cmd_a, e);
      if (i < 15) acc += int'(cmd_a[15:0]);
    end
    chk("oor_err0", err_a, 2'b01); chk("oor_continue", cmd_en_a, 1);
    cmd_id = '0;

    // single result, res_en held high for 5 cycles
    res = CMD_W'(acc); res_en = 1;
    exp_q.push_back(32'h13BA);
    tick();
    chk("done_cmd_en", cmd_en_a, 0); chk("done_busy", busy_a, 0);
    repeat (4) tick();
    res_en = 0;
    chk("b_still_run", cmd_en_b, 1);
    chk("res_a", rd_data_a, exp_q[0]); chk("res_b", rd_data_b, exp_q[0]);
    void'(exp_q.pop_front());
    rd_en = 1; tick(); rd_en = 0;
    chk("one_entry_a", rd_empty_a, 1); chk("one_entry_b", rd_empty_b, 1);

    // load DEPTH+2 words
    ld_start = 1; tick(); ld_start = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      chk("ovf_ld_ready", ld_ready_a, (i < DEPTH) ? 1'b1 : 1'b0);
      ld_data = 32'hC000_0000 | i; ld_valid = 1; tick();
    end
    ld_valid = 0;
    chk("ovf_err1", err_a[1], 1);
    ld_done = 1; tick(); ld_done = 0;
    chk("ovf_prog_len", prog_len_a, DEPTH);
    run = 1; tick(); run = 0;
    cmd_id = 8'd15; exp_q.push_back(32'hC000_000F); tick();
    e = exp_q.pop_front(); chk("last_word", cmd_a, e);
    // ld_start during RUN drops cmd_en
    ld_start = 1; tick(); ld_start = 0;
    chk("ldstart_run_cmd_en", cmd_en_a, 0); chk("ldstart_run_load", ld_ready_a, 1);
    ld_done = 1; tick(); ld_done = 0;
    cmd_id = '0;

    // async reset mid-RUN
    ld_start = 1; tick(); ld_start = 0;
    ld_data = 32'h1234_5678; ld_valid = 1; ld_done = 1; tick(); ld_valid = 0; ld_done = 0;
    chk("one_word_len", prog_len_a, 1);
    run = 1; tick(); run = 0;
    chk("pre_rst_cmd_en", cmd_en_a, 1);
    #2 sys_rst_n = 1'b0; #1;
    chk("async_rst_cmd_en", cmd_en_a, 0); chk("async_rst_busy", busy_a, 0);
    #3 sys_rst_n = 1'b1;
    tick();
    run = 1; tick(); run = 0; tick();
    chk("post_rst_run_ign", cmd_en_a, 0); chk("post_rst_len", prog_len_a, 0);

    // FIFO overflow on b: 6 pulses, 4 retained
    ld_start = 1; tick(); ld_start = 0;
    for (int i = 0; i < 2; i++) begin
      ld_data = 32'h77 + i; ld_valid = 1; ld_done = (i == 1); tick();
    end
    ld_valid = 0; ld_done = 0;
    run = 1; tick(); run = 0;
    for (int k = 0; k < 6; k++) begin
      res = 32'h100 + k; res_en = 1; tick(); res_en = 0; tick();
      if (k < 4) exp_q.push_back(32'h100 + k);
    end
    chk("fifo_err", err_b, 2'b10); chk("fifo_not_empty", rd_empty_b, 0);
    chk("fifo_head", rd_data_b, exp_q[0]);
    // push and pop together while full
    res = 32'h1FF; res_en = 1; rd_en = 1;
    void'(exp_q.pop_front()); exp_q.push_back(32'h1FF);
    tick(); res_en = 0; rd_en = 0;
    chk("full_pushpop_err", err_b, 2'b10);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      chk("fifo_pop", rd_data_b, e);
      rd_en = 1; tick(); rd_en = 0;
    end
    chk("fifo_drained", rd_empty_b, 1); chk("fifo_empty_data", rd_data_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
